// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared definitions for the MIPS fetch stage: the bubble encoding, the fetch
//   FSM state type, the default boot address, the widths of the decoder Imm and
//   Jaddress fields, and a helper that turns a branch immediate into a byte
//   offset.
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Sign-extended word offset scaled to bytes (imm << 2).
    function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     instr_pc      in   address of the instruction in the instruction register
//     fetch_pc      in   address of the word currently on imem_rdata
//     instr_valid   in   instruction register holds a live instruction
//     branch_taken  in   PC-relative redirect request
//     branch_imm    in   branch immediate (words, signed)
//     jump          in   J-type redirect request
//     jump_addr     in   J-type target field
//     jr            in   register redirect request
//     jr_target     in   register value for jr
//     next_pc       out  address to fetch next
//     redirect      out  a redirect is being taken this cycle
//     jr_misaligned out  the taken redirect is a jr with nonzero low bits
// ---------------------------------------------------------------------------
module pc_next_calc
    import instruction_fetch_pkg::*;
(
    input  logic [31:0]        instr_pc,
    input  logic [31:0]        fetch_pc,
    input  logic               instr_valid,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   branch_imm,
    input  logic               jump,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    output logic [31:0]        next_pc,
    output logic               redirect,
    output logic               jr_misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] jr_pc;

    // Redirect targets are relative to the decoded instruction, not to the
    // word in flight; there is no delay slot.
    assign seq_pc    = instr_pc + 32'd4;
    assign branch_pc = seq_pc + branch_offset(branch_imm);
    assign jump_pc   = {seq_pc[31:28], jump_addr, 2'b00};
    assign jr_pc     = {jr_target[31:2], 2'b00};

    // NOTE: every output gets a default before the if-chain, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_pc       = fetch_pc + 32'd4;
        redirect      = 1'b0;
        jr_misaligned = 1'b0;
        // A bubble carries no real control decision, so its redirect inputs
        // are ignored.
        if (instr_valid) begin
            if (jr) begin
                next_pc       = jr_pc;
                redirect      = 1'b1;
                jr_misaligned = (jr_target[1:0] != 2'b00);
            end else if (jump) begin
                next_pc  = jump_pc;
                redirect = 1'b1;
            end else if (branch_taken) begin
                next_pc  = branch_pc;
                redirect = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   MIPS fetch stage: owns the PC, drives a synchronous-read instruction
//   memory, and captures each returned word into the instruction register
//   feeding the decoder. Redirects cost one squashed bubble.
//   Ports:
//     clk, reset     rising-edge clock, async active-high reset
//     imem_addr/en   word address and read enable to instruction memory
//     imem_rdata     memory data, valid the cycle after the address edge
//     stall          freeze fetch and the instruction register
//     branch_taken/branch_imm, jump/jump_addr, jr/jr_target  redirects
//     instruction    instruction register (to decoder)
//     instr_pc       address of instruction
//     instr_valid    0 = bubble
//     fetch_fault    sticky misaligned-jr flag
//     instr_count    valid instructions delivered since reset (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    output logic               imem_en,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   branch_imm,
    input  logic               jump,
    input  logic [JADDR_W-1:0] jump_addr,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    output logic [31:0]        instruction,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    output logic               fetch_fault,
    output logic [31:0]        instr_count
);

    fetch_state_t state, state_next;

    logic [31:0] fetch_pc;
    logic        fetch_valid;

    logic [31:0] next_pc;
    logic        redirect;
    logic        jr_misaligned;

    // Control decoded from the FSM.
    logic        boot_load;
    logic        run_load;
    logic        load_valid;

    pc_next_calc u_pc_next_calc (
        .instr_pc      (instr_pc),
        .fetch_pc      (fetch_pc),
        .instr_valid   (instr_valid),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_addr     (jump_addr),
        .jr            (jr),
        .jr_target     (jr_target),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .jr_misaligned (jr_misaligned)
    );

    // ---------------------------------------------------------------------
    // FSM next-state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        imem_en    = 1'b1;
        imem_addr  = RESET_PC;
        boot_load  = 1'b0;
        run_load   = 1'b0;
        unique case (state)
            BOOT: begin
                // Stall and redirects are not looked at while booting.
                boot_load  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                imem_addr = next_pc;
                if (stall) begin
                    // Memory holds its output, keeping fetch_pc's word on
                    // imem_rdata for when the stall releases.
                    imem_en = 1'b0;
                end else begin
                    run_load = 1'b1;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // The word in flight behind a redirect is squashed.
    assign load_valid = run_load & fetch_valid & ~redirect;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            fetch_valid <= 1'b0;
            instruction <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            state <= state_next;
            if (boot_load) begin
                fetch_pc    <= RESET_PC;
                fetch_valid <= 1'b1;
            end
            if (run_load) begin
                instruction <= imem_rdata;
                instr_pc    <= fetch_pc;
                instr_valid <= load_valid;
                fetch_pc    <= next_pc;
                fetch_valid <= 1'b1;
                if (jr_misaligned) begin
                    fetch_fault <= 1'b1;
                end
            end
            if (load_valid) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. The instruction memory model returns
//   32'h2000_0000 + word_index for any address, one cycle after the address
//   edge, and holds its output while imem_en is low.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_addr;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;

    instruction_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .jr           (jr),
        .jr_target    (jr_target),
        .instruction  (instruction),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .fetch_fault  (fetch_fault),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h2000_0000 + (imem_addr >> 2);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc,
                                input logic [31:0] word, input logic [31:0] cnt);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        check({tag, "_pc"},    instr_pc,    pc);
        check({tag, "_instr"}, instruction, word);
        check({tag, "_count"}, instr_count, cnt);
    endtask

    task automatic expect_reset_values(input string tag);
        check({tag, "_instr"}, instruction, 32'h0);
        check({tag, "_pc"},    instr_pc,    32'h0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
        check({tag, "_count"}, instr_count, 32'd0);
        check({tag, "_en"},    {31'b0, imem_en},     32'd1);
        check({tag, "_addr"},  imem_addr,   32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_imm = 16'h0;
        jump = 1'b0; jump_addr = 26'h0;
        jr = 1'b0; jr_target = 32'h0;

        tick(); tick();
        expect_reset_values("rst");

        // Boot and sequential fetch
        reset = 1'b0;
        tick();
        check("boot_valid", {31'b0, instr_valid}, 32'd0);
        check("boot_addr",  imem_addr, 32'h4);
        tick(); expect_instr("seq0", 32'h0, 32'h2000_0000, 32'd1);
        tick(); expect_instr("seq1", 32'h4, 32'h2000_0001, 32'd2);
        tick(); expect_instr("seq2", 32'h8, 32'h2000_0002, 32'd3);

        // Backward branch at pc 8 -> 4; held through the bubble, where it must be ignored
        branch_taken = 1'b1; branch_imm = 16'hFFFE;
        #1 check("br_addr", imem_addr, 32'h4);
        tick();
        check("br_bubble", {31'b0, instr_valid}, 32'd0);
        check("br_bubble_count", instr_count, 32'd3);
        tick(); expect_instr("br_tgt", 32'h4, 32'h2000_0001, 32'd4);
        branch_taken = 1'b0;
        tick(); expect_instr("br_next", 32'h8, 32'h2000_0002, 32'd5);

        // Stall for three cycles with a branch pending
        stall = 1'b1; branch_taken = 1'b1;
        #1 check("stall_en0", {31'b0, imem_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_instr("stall_hold", 32'h8, 32'h2000_0002, 32'd5);
            check("stall_en", {31'b0, imem_en}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("stall_br_bubble", {31'b0, instr_valid}, 32'd0);
        check("stall_br_count",  instr_count, 32'd5);
        branch_taken = 1'b0;
        tick(); expect_instr("stall_br_tgt", 32'h4, 32'h2000_0001, 32'd6);

        // Aligned jr to 0x1000_0010
        jr = 1'b1; jr_target = 32'h1000_0010;
        tick();
        check("jr_bubble", {31'b0, instr_valid}, 32'd0);
        check("jr_fault",  {31'b0, fetch_fault}, 32'd0);
        jr = 1'b0;
        tick(); expect_instr("jr_tgt", 32'h1000_0010, 32'h2400_0004, 32'd7);

        // Jump keeps the upper nibble of pc+4
        jump = 1'b1; jump_addr = 26'h40;
        tick();
        check("j_bubble", {31'b0, instr_valid}, 32'd0);
        jump = 1'b0;
        tick(); expect_instr("j_tgt", 32'h1000_0100, 32'h2400_0040, 32'd8);

        // All three redirects together: jr wins, misaligned target faults
        jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jr_target = 32'h0000_0203; branch_imm = 16'hFFFE; jump_addr = 26'h40;
        #1 check("all_addr", imem_addr, 32'h200);
        tick();
        check("all_bubble", {31'b0, instr_valid}, 32'd0);
        check("all_fault",  {31'b0, fetch_fault}, 32'd1);
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        tick(); expect_instr("all_tgt", 32'h200, 32'h2000_0080, 32'd9);
        check("fault_sticky1", {31'b0, fetch_fault}, 32'd1);
        tick(); expect_instr("all_next", 32'h204, 32'h2000_0081, 32'd10);
        check("fault_sticky2", {31'b0, fetch_fault}, 32'd1);

        // Reset during the bubble after a redirect
        branch_taken = 1'b1; branch_imm = 16'hFFFE;
        tick();
        check("rb_bubble", {31'b0, instr_valid}, 32'd0);
        reset = 1'b1;
        #1 expect_reset_values("rst_async");
        branch_taken = 1'b0;
        tick();
        expect_reset_values("rst_hold");
        reset = 1'b0;
        tick();
        check("reboot_valid", {31'b0, instr_valid}, 32'd0);
        tick(); expect_instr("reboot0", 32'h0, 32'h2000_0000, 32'd1);
        check("reboot_fault", {31'b0, fetch_fault}, 32'd0);
        tick(); expect_instr("reboot1", 32'h4, 32'h2000_0001, 32'd2);

        // Forward branch: pc 4, imm 3 -> 8 + 12 = 0x14
        branch_taken = 1'b1; branch_imm = 16'h0003;
        tick();
        check("fbr_bubble", {31'b0, instr_valid}, 32'd0);
        branch_taken = 1'b0;
        tick(); expect_instr("fbr_tgt", 32'h14, 32'h2000_0005, 32'd3);

        // PC wrap from 0xFFFF_FFFC to 0
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        tick();
        check("wrap_bubble", {31'b0, instr_valid}, 32'd0);
        jr = 1'b0;
        tick(); expect_instr("wrap_top", 32'hFFFF_FFFC, 32'h5FFF_FFFF, 32'd4);
        tick(); expect_instr("wrap_zero", 32'h0, 32'h2000_0000, 32'd5);
        check("wrap_fault", {31'b0, fetch_fault}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
